// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: ROM read port, branch redirect and the {pc, inst} handshake to decode.
interface inst_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic              rom_ce;
   logic [ADDR_W-1:0] rom_addr;
   logic [INST_W-1:0] rom_inst;
   logic              branch_flag;
   logic [ADDR_W-1:0] branch_target;
   logic              id_valid;
   logic              id_ready;
   logic [ADDR_W-1:0] id_pc;
   logic [INST_W-1:0] id_inst;
   logic              if_excpt;

   modport master (
      output rom_ce, rom_addr, id_valid, id_pc, id_inst, if_excpt,
      input  rom_inst, branch_flag, branch_target, id_ready
   );

   modport slave (
      input  rom_ce, rom_addr, id_valid, id_pc, id_inst, if_excpt,
      output rom_inst, branch_flag, branch_target, id_ready
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC owner, ROM read initiator and prefetch FIFO feeding decode.
// Optional macro ALIGN_CHECK_EN enables the sticky misaligned-branch-target fault.
module inst_fetch #(
   parameter int                ADDR_W     = 32,
   parameter int                INST_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   inst_fetch_if.master bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic              run_q;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];
   logic [INST_W-1:0] inst_mem_q [FIFO_DEPTH];

   logic              fault;
   logic              fetch;
   logic              pop;
   logic [ADDR_W-1:0] target_load;

`ifdef ALIGN_CHECK_EN
   logic fault_q;

   assign target_load = bus.branch_target;

   // Sticky until the next aligned redirect; the faulting target is still loaded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fault_q <= 1'b0;
      end else if (bus.branch_flag) begin
         fault_q <= (bus.branch_target[1:0] != 2'b00);
      end
   end

   assign fault = fault_q;
`else
   assign target_load = bus.branch_target & ~ADDR_W'(3);
   assign fault       = 1'b0;
`endif

   assign bus.id_valid = (count_q != '0);
   assign pop          = bus.id_valid & bus.id_ready;
   // A full FIFO may still fetch when the head leaves in the same cycle.
   assign fetch        = run_q & ~bus.branch_flag & ~fault & ((count_q < DEPTH_C) | pop);

   assign bus.rom_ce   = fetch;
   assign bus.rom_addr = pc_q;
   assign bus.id_pc    = pc_mem_q[rd_ptr_q];
   assign bus.id_inst  = inst_mem_q[rd_ptr_q];
   assign bus.if_excpt = fault;

   always_comb begin
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.branch_flag) begin
         pc_d     = target_load;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (fetch) begin
            pc_d     = pc_q + ADDR_W'(4);
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({fetch, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q    <= 1'b0;
         pc_q     <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         run_q    <= 1'b1;
         pc_q     <= pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               pc_mem_q[gi]   <= '0;
               inst_mem_q[gi] <= '0;
            end else if (fetch && (wr_ptr_q == PTR_W'(gi))) begin
               pc_mem_q[gi]   <= pc_q;
               inst_mem_q[gi] <= bus.rom_inst;
            end
         end
      end
   endgenerate
endmodule
